// File: rtl/regfile_write_arbiter_if.sv
// Bundle for the shared register-file write port. The pipeline writeback (P),
// the multi-cycle unit (M), the register-file write port and the hazard-unit
// taps all travel through this bundle.
//
// Handshake: the M result moves into the arbiter on the posedge where
// m_valid && m_ready are both high. The producer holds m_valid, m_addr and
// m_data stable until that edge. m_ready may depend on p_valid in the same
// cycle. P has no ready signal. When pipe_stall is high, P was not written
// and must be replayed on the next cycle.
interface regfile_write_arbiter_if;
  logic        p_valid;
  logic [4:0]  p_addr;
  logic [31:0] p_data;
  logic        m_valid;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        m_ready;
  logic        writeEnable;
  logic [4:0]  addressWrite;
  logic [31:0] dataWrite;
  logic        pipe_stall;
  logic        pend_valid;
  logic [4:0]  pend_addr;
  logic        m_drop;

  // Producer/consumer side: drives P and M, observes the arbiter.
  modport master (
    output p_valid, p_addr, p_data, m_valid, m_addr, m_data,
    input  m_ready, writeEnable, addressWrite, dataWrite,
           pipe_stall, pend_valid, pend_addr, m_drop
  );

  // Arbiter side.
  modport slave (
    input  p_valid, p_addr, p_data, m_valid, m_addr, m_data,
    output m_ready, writeEnable, addressWrite, dataWrite,
           pipe_stall, pend_valid, pend_addr, m_drop
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port between the pipeline writeback
// (P, never back-pressured, has priority) and a multi-cycle unit (M, valid/ready).
// An accepted M result waits in a one-entry hold register. If it waits
// STARVE_LIMIT cycles, the arbiter stalls the pipeline for one cycle so the
// held entry can drain. When P writes the held destination, the held entry is
// discarded (WAW). The register file writes on negedge, so all write-port
// outputs are combinational and settle during the high phase.
module regfile_write_arbiter #(
  parameter int STARVE_LIMIT  = 4,
  parameter bit ZERO_WRITABLE = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,      // asynchronous, active low
  regfile_write_arbiter_if.slave bus,
  output logic [1:0]             state_o   // debug view of the FSM state
);

  localparam int WCW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [WCW-1:0] LIMIT = WCW'(STARVE_LIMIT);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_FORCE = 2'd2;

  logic           hold_v_q,    hold_v_d;
  logic [4:0]     hold_addr_q, hold_addr_d;
  logic [31:0]    hold_data_q, hold_data_d;
  logic [WCW-1:0] wcnt_q,      wcnt_d;
  logic [1:0]     state_q,     state_d;

  logic        in_force;
  logic        grant_p;
  logic        grant_m;
  logic        drop;
  logic        m_ready_w;
  logic        accept;
  logic [4:0]  tgt_addr;
  logic [31:0] tgt_data;

  // Grant decision. FORCE overrides P, P overrides the held entry.
  // Every grant is gated by rst, so all outputs read zero while reset is active.
  always_comb begin
    in_force = 1'b0;
    grant_p  = 1'b0;
    grant_m  = 1'b0;
    drop     = 1'b0;
    if (rst) begin
      in_force = (state_q == S_FORCE);
      if (in_force) begin
        grant_m = 1'b1;
      end else if (bus.p_valid) begin
        grant_p = 1'b1;
      end else if (hold_v_q) begin
        grant_m = 1'b1;
      end
      // P overwrites the held destination, so the older M value must never land.
      drop = !in_force && bus.p_valid && hold_v_q && (bus.p_addr == hold_addr_q);
    end
  end

  // Drive the write port from the granted source. A write to r0 still counts
  // as granted, so the entry drains, but the enable is suppressed.
  always_comb begin
    tgt_addr = 5'd0;
    tgt_data = 32'd0;
    if (grant_p) begin
      tgt_addr = bus.p_addr;
      tgt_data = bus.p_data;
    end else if (grant_m) begin
      tgt_addr = hold_addr_q;
      tgt_data = hold_data_q;
    end
    bus.addressWrite = tgt_addr;
    bus.dataWrite    = tgt_data;
    bus.writeEnable  = (grant_p || grant_m) && (ZERO_WRITABLE || (tgt_addr != 5'd0));
  end

  // Handshake and hazard-unit outputs. The hold register may refill in the
  // same cycle it drains or is dropped, so back-to-back M results see no bubble.
  always_comb begin
    m_ready_w      = rst && (!hold_v_q || grant_m || drop);
    accept         = bus.m_valid && m_ready_w;
    bus.m_ready    = m_ready_w;
    bus.pipe_stall = in_force;
    bus.m_drop     = drop;
    bus.pend_valid = hold_v_q;
    bus.pend_addr  = hold_v_q ? hold_addr_q : 5'd0;
    state_o        = state_q;
  end

  // Next state for the hold register, the wait counter and the FSM.
  always_comb begin
    hold_v_d    = hold_v_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    wcnt_d      = wcnt_q;
    if (accept) begin
      hold_v_d    = 1'b1;
      hold_addr_d = bus.m_addr;
      hold_data_d = bus.m_data;
      wcnt_d      = '0;
    end else if (grant_m || drop) begin
      hold_v_d = 1'b0;
      wcnt_d   = '0;
    end else if (hold_v_q && (wcnt_q < LIMIT)) begin
      wcnt_d = wcnt_q + WCW'(1);
    end

    if (!hold_v_d) begin
      state_d = S_EMPTY;
    end else if (wcnt_d == LIMIT) begin
      state_d = S_FORCE;
    end else begin
      state_d = S_WAIT;
    end
  end

  // State registers. Reset silently discards any held entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_v_q    <= 1'b0;
      hold_addr_q <= 5'd0;
      hold_data_q <= 32'd0;
      wcnt_q      <= '0;
      state_q     <= S_EMPTY;
    end else begin
      hold_v_q    <= hold_v_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
      wcnt_q      <= wcnt_d;
      state_q     <= state_d;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter (STARVE_LIMIT=4, ZERO_WRITABLE=0).
// Every register-file write the stimulus should cause is pushed to exp_q.
// The negedge monitor pops one entry for each observed writeEnable.
module tb_regfile_write_arbiter;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_FORCE = 2'd2;

  logic       clk;
  logic       rst;
  logic [1:0] state_o;

  regfile_write_arbiter_if bus();

  regfile_write_arbiter #(.STARVE_LIMIT(4), .ZERO_WRITABLE(1'b0)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_o)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];

  task automatic check(input string tag, input logic [36:0] obs, input logic [36:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver tasks.
  task automatic drive_p(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.p_valid = v;
    bus.p_addr  = a;
    bus.p_data  = d;
  endtask

  task automatic drive_m(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.m_valid = v;
    bus.m_addr  = a;
    bus.m_data  = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // Scoreboard: every write that reaches the register file must be the oldest expected one.
  always @(negedge clk) begin
    if (bus.writeEnable === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {bus.addressWrite, bus.dataWrite}, 37'h0);
        if ({bus.addressWrite, bus.dataWrite} == 37'h0) begin
          errors++;
          $error("FAIL unexpected_write observed=%h expected=none", {bus.addressWrite, bus.dataWrite});
        end
      end else begin
        check("write_port", {bus.addressWrite, bus.dataWrite}, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b0;
    drive_p(1'b0, 5'd0, 32'd0);
    drive_m(1'b1, 5'd5, 32'hA5A5A5A5);

    // 1. Reset holds everything low, even with m_valid high.
    at_neg();
    check("rst_m_ready",  37'(bus.m_ready), 37'd0);
    check("rst_we",       37'(bus.writeEnable), 37'd0);
    check("rst_outputs",  {bus.addressWrite, bus.dataWrite}, 37'd0);
    check("rst_misc",     37'({bus.pipe_stall, bus.pend_valid, bus.pend_addr, bus.m_drop}), 37'd0);
    next_cycle();
    rst = 1'b1;
    at_neg();
    check("t1_m_ready", 37'(bus.m_ready), 37'd1);
    push_exp(5'd5, 32'hA5A5A5A5);
    next_cycle();
    drive_m(1'b0, 5'd0, 32'd0);
    at_neg();
    check("t1_pend_valid", 37'(bus.pend_valid), 37'd1);
    check("t1_pend_addr",  37'(bus.pend_addr), 37'd5);
    check("t1_we",         37'(bus.writeEnable), 37'd1);
    check("t1_addr",       37'(bus.addressWrite), 37'd5);
    check("t1_state",      37'(state_o), 37'(S_WAIT));
    next_cycle();
    at_neg();
    check("t1_drained", 37'(bus.pend_valid), 37'd0);
    check("t1_state_e", 37'(state_o), 37'(S_EMPTY));

    // 2. Starvation: P every cycle while r7 is held.
    next_cycle();
    drive_p(1'b1, 5'd3, 32'h11);
    drive_m(1'b1, 5'd7, 32'h22);
    push_exp(5'd3, 32'h11);
    at_neg();
    check("t2_accept", 37'(bus.m_ready), 37'd1);
    next_cycle();
    drive_m(1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      push_exp(5'd3, 32'h11);
      at_neg();
      check("t2_no_stall", 37'(bus.pipe_stall), 37'd0);
      check("t2_held",     37'({bus.pend_valid, bus.pend_addr}), 37'({1'b1, 5'd7}));
      next_cycle();
    end
    push_exp(5'd7, 32'h22);
    at_neg();
    check("t2_stall", 37'(bus.pipe_stall), 37'd1);
    check("t2_state", 37'(state_o), 37'(S_FORCE));
    next_cycle();
    push_exp(5'd3, 32'h11);
    at_neg();
    check("t2_pend_clear", 37'(bus.pend_valid), 37'd0);
    check("t2_stall_off",  37'(bus.pipe_stall), 37'd0);
    next_cycle();
    drive_p(1'b0, 5'd0, 32'd0);

    // 3. WAW drop: P writes r9 while r9 is held.
    drive_p(1'b1, 5'd1, 32'h01);
    drive_m(1'b1, 5'd9, 32'h99);
    push_exp(5'd1, 32'h01);
    next_cycle();
    drive_m(1'b0, 5'd0, 32'd0);
    drive_p(1'b1, 5'd9, 32'h55);
    push_exp(5'd9, 32'h55);
    at_neg();
    check("t3_drop",    37'(bus.m_drop), 37'd1);
    check("t3_m_ready", 37'(bus.m_ready), 37'd1);
    next_cycle();
    drive_p(1'b0, 5'd0, 32'd0);
    at_neg();
    check("t3_drop_off", 37'(bus.m_drop), 37'd0);
    check("t3_pend",     37'(bus.pend_valid), 37'd0);
    for (int i = 0; i < 3; i++) next_cycle();

    // 4. Drain and refill in the same cycle.
    drive_p(1'b1, 5'd2, 32'h02);
    drive_m(1'b1, 5'd8, 32'h88);
    push_exp(5'd2, 32'h02);
    next_cycle();
    drive_p(1'b0, 5'd0, 32'd0);
    drive_m(1'b1, 5'd4, 32'h44);
    push_exp(5'd8, 32'h88);
    at_neg();
    check("t4_m_ready", 37'(bus.m_ready), 37'd1);
    next_cycle();
    drive_m(1'b0, 5'd0, 32'd0);
    push_exp(5'd4, 32'h44);
    at_neg();
    check("t4_reload", 37'({bus.pend_valid, bus.pend_addr}), 37'({1'b1, 5'd4}));
    next_cycle();
    at_neg();
    check("t4_empty", 37'(bus.pend_valid), 37'd0);

    // 5. M result to r0 drains without a write.
    next_cycle();
    drive_m(1'b1, 5'd0, 32'h77);
    next_cycle();
    drive_m(1'b0, 5'd0, 32'd0);
    at_neg();
    check("t5_we_r0", 37'(bus.writeEnable), 37'd0);
    check("t5_pend",  37'({bus.pend_valid, bus.pend_addr}), 37'({1'b1, 5'd0}));
    next_cycle();
    at_neg();
    check("t5_pend_clear", 37'(bus.pend_valid), 37'd0);

    // 6. Asynchronous reset while the entry has waited three cycles.
    next_cycle();
    drive_p(1'b1, 5'd10, 32'hA0);
    drive_m(1'b1, 5'd12, 32'hC0);
    push_exp(5'd10, 32'hA0);
    next_cycle();
    drive_m(1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      push_exp(5'd10, 32'hA0);
      next_cycle();
    end
    rst = 1'b0;
    #1;
    check("t6_async_zero", {bus.writeEnable, bus.addressWrite, bus.dataWrite}, 37'd0);
    check("t6_async_misc", 37'({bus.m_ready, bus.pipe_stall, bus.pend_valid, bus.pend_addr, bus.m_drop}), 37'd0);
    at_neg();
    check("t6_state", 37'(state_o), 37'(S_EMPTY));
    next_cycle();
    drive_p(1'b0, 5'd0, 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      at_neg();
      check("t6_no_drop",  37'(bus.m_drop), 37'd0);
      check("t6_no_stale", 37'({bus.writeEnable, bus.pend_valid}), 37'd0);
      next_cycle();
    end

    // Final report.
    check("exp_q_empty", 37'(exp_q.size()), 37'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
